// File: rtl/strength_pkg.sv
// Shared strength/value encodings, FSM state type and the pure group
// resolution function used by the strength resolve stage.
package strength_pkg;

    typedef enum logic [2:0] {
        STR_HIGHZ  = 3'd0,
        STR_SMALL  = 3'd1,
        STR_MEDIUM = 3'd2,
        STR_WEAK   = 3'd3,
        STR_LARGE  = 3'd4,
        STR_PULL   = 3'd5,
        STR_STRONG = 3'd6,
        STR_SUPPLY = 3'd7
    } strength_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [1:0] VAL_0 = 2'b00;
    localparam logic [1:0] VAL_1 = 2'b01;
    localparam logic [1:0] VAL_Z = 2'b10;
    localparam logic [1:0] VAL_X = 2'b11;

    typedef struct packed {
        logic [1:0] val;
        strength_e  str;
    } resolved_t;

    function automatic strength_e str_max(input strength_e a, input strength_e b);
        return (a > b) ? a : b;
    endfunction

    // Strongest component wins; equal non-zero components collide to x.
    function automatic resolved_t resolve(input strength_e max0, input strength_e max1);
        resolved_t r;
        r.val = VAL_Z;
        r.str = STR_HIGHZ;
        if (max0 > max1) begin
            r.val = VAL_0;
            r.str = max0;
        end else if (max1 > max0) begin
            r.val = VAL_1;
            r.str = max1;
        end else if (max0 != STR_HIGHZ) begin
            r.val = VAL_X;
            r.str = max0;
        end
        return r;
    endfunction

endpackage

// File: rtl/strength_accum.sv
// Per-group accumulator: running 0/1 strength maxima, saturating driver
// count and sticky overflow flag.
module strength_accum
    import strength_pkg::*;
#(
    parameter int MAX_DRIVERS = 8,
    parameter int CNT_W       = $clog2(MAX_DRIVERS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_en,
    input  logic             first_beat,
    input  logic [1:0]       beat_val,
    input  logic [2:0]       beat_str0,
    input  logic [2:0]       beat_str1,
    output strength_e        max0,
    output strength_e        max1,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    strength_e        max0_q, max0_d;
    strength_e        max1_q, max1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    strength_e        c0, c1;

    always_comb begin
        c0 = (beat_val == VAL_0 || beat_val == VAL_X) ? strength_e'(beat_str0) : STR_HIGHZ;
        c1 = (beat_val == VAL_1 || beat_val == VAL_X) ? strength_e'(beat_str1) : STR_HIGHZ;
    end

    always_comb begin
        max0_d = max0_q;
        max1_d = max1_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (beat_en) begin
            if (first_beat) begin
                // A new group starts fresh rather than merging with the last one.
                max0_d = c0;
                max1_d = c1;
                cnt_d  = CNT_W'(1);
                ovf_d  = 1'b0;
            end else begin
                max0_d = str_max(max0_q, c0);
                max1_d = str_max(max1_q, c1);
                if (cnt_q == CNT_W'(MAX_DRIVERS)) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max0_q <= STR_HIGHZ;
            max1_q <= STR_HIGHZ;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            max0_q <= max0_d;
            max1_q <= max1_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign max0 = max0_q;
    assign max1 = max1_q;
    assign cnt  = cnt_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/strength_resolve_stage.sv
// Collects driver beats of one net group, resolves the net value/strength
// and presents it on a valid/ready output until consumed.
module strength_resolve_stage
    import strength_pkg::*;
#(
    parameter int MAX_DRIVERS = 8,
    parameter int CNT_W       = $clog2(MAX_DRIVERS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drv_valid,
    output logic             drv_ready,
    input  logic [1:0]       drv_val,
    input  logic [2:0]       drv_str0,
    input  logic [2:0]       drv_str1,
    input  logic             drv_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_val,
    output logic [2:0]       res_str,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf
);

    state_e    state_q, state_d;
    logic      beat_acc;
    strength_e max0, max1;
    resolved_t resolved;

    // Ready is gated by rst_n so nothing is taken while reset is held.
    assign drv_ready = rst_n && (state_q != S_HOLD);
    assign beat_acc  = drv_valid && drv_ready;
    assign res_valid = (state_q == S_HOLD);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    state_d = drv_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_acc && drv_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    strength_accum #(
        .MAX_DRIVERS (MAX_DRIVERS),
        .CNT_W       (CNT_W)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_en    (beat_acc),
        .first_beat (state_q == S_IDLE),
        .beat_val   (drv_val),
        .beat_str0  (drv_str0),
        .beat_str1  (drv_str1),
        .max0       (max0),
        .max1       (max1),
        .cnt        (res_cnt),
        .ovf        (res_ovf)
    );

    // Maxima cannot change in HOLD, so the resolved value is stable while stalled.
    assign resolved = resolve(max0, max1);
    assign res_val  = resolved.val;
    assign res_str  = resolved.str;

endmodule

// File: doc/strength_resolve_stage.md
STRENGTH_RESOLVE_STAGE -- requirements
Module: strength_resolve_stage

Interface
REQ-001 SHALL have parameter MAX_DRIVERS, default 8, meaning the maximum number of driver beats per net group without overflow.
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_DRIVERS+1), meaning the driver-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port drv_valid  input  1  driver beat offered.
REQ-006 SHALL have port drv_ready  output  1  stage accepts a driver beat.
REQ-007 SHALL have port drv_val  input  2  4-state driven value: 00=0, 01=1, 10=z, 11=x.
REQ-008 SHALL have port drv_str0  input  3  strength of the 0 component (0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull, 6 strong, 7 supply).
REQ-009 SHALL have port drv_str1  input  3  strength of the 1 component, same encoding.
REQ-010 SHALL have port drv_last  input  1  final driver of the current net group.
REQ-011 SHALL have port res_valid  output  1  resolved net value available.
REQ-012 SHALL have port res_ready  input  1  downstream consumes the result.
REQ-013 SHALL have port res_val  output  2  resolved 4-state value, same encoding.
REQ-014 SHALL have port res_str  output  3  resolved strength.
REQ-015 SHALL have port res_cnt  output  CNT_W  drivers in the group, saturating at MAX_DRIVERS.
REQ-016 SHALL have port res_ovf  output  1  group exceeded MAX_DRIVERS beats.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-018 SHALL transition IDLE->ACCUM on an accepted beat with drv_last=0, IDLE->HOLD on an accepted beat with drv_last=1, ACCUM->HOLD on an accepted beat with drv_last=1, and HOLD->IDLE when res_valid && res_ready.
REQ-019 SHALL drive drv_ready=1 in IDLE and ACCUM and drv_ready=0 in HOLD, so no beat is accepted in the cycle a result is consumed.
REQ-020 SHALL treat a beat as accepted only when drv_valid && drv_ready.
REQ-021 SHALL, per accepted beat, take c0=drv_str0 if drv_val is 0 or x (else 0), take c1=drv_str1 if drv_val is 1 or x (else 0), and contribute nothing for z.
REQ-022 SHALL update running maxima as max0=max(max0,c0) and max1=max(max1,c1), with the first beat of a group overwriting (not merging with) the previous group's maxima.
REQ-023 SHALL resolve the group as: max0>max1 -> value 0, strength max0; max1>max0 -> value 1, strength max1; max0==max1!=0 -> value x, strength max0; both 0 -> value z, strength 0.
REQ-024 SHALL assert res_valid exactly in HOLD, one cycle after the drv_last beat is accepted (latency 1).
REQ-025 SHALL hold res_val, res_str, res_cnt and res_ovf stable while res_valid=1 && res_ready=0.
REQ-026 SHALL increment res_cnt once per accepted beat, saturating at MAX_DRIVERS.
REQ-027 SHALL set res_ovf sticky within a group when a beat is accepted with the count already at MAX_DRIVERS, and SHALL still resolve that beat.
REQ-028 SHALL ignore drv_val, drv_str0, drv_str1 and drv_last when no beat is accepted.

Reset
REQ-029 SHALL, on rst_n low, force state IDLE, drv_ready=0 while reset is asserted, res_valid=0, res_val=z (10), res_str=0, res_cnt=0, res_ovf=0, max0=0 and max1=0.
REQ-030 SHALL, when reset is asserted mid-group or in HOLD, discard the partial or pending result with no output beat.
REQ-031 SHALL drive drv_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL take its strength typedef (3-bit enum, highz..supply), 4-state value encoding constants and a pure resolve function from shared package strength_pkg.
REQ-033 SHALL place the maxima, count and overflow tracking in one sub-module, strength_accum; the FSM and handshake SHALL stay in the top level.

Verification
REQ-034 SHALL verify: group {0 weak, 1 pull, x strong, last} -> res_val=x, res_str=6, res_cnt=3.
REQ-035 SHALL verify: group {0 weak, 1 pull, last} -> res_val=1, res_str=5.
REQ-036 SHALL verify: group {z, z, last} -> res_val=z, res_str=0; then single {0 supply, last} -> res_val=0, res_str=7, no carry-over from the previous group.
REQ-037 SHALL verify: 9 beats with MAX_DRIVERS=8 -> res_cnt=8, res_ovf=1, and the resolution includes the 9th beat.
REQ-038 SHALL verify: res_ready held 0 for 5 cycles -> outputs stable, drv_ready=0, offered beats not consumed.
REQ-039 SHALL verify: rst_n pulsed low after 2 beats of a group -> no res_valid; the next group resolves independently.
